dense_layer_seq: RTL and testbench

- Parametrised, time-multiplexed fully-connected layer. Successor to the fixed 4-input hidden neuron and 8-input output neuron.
- One shared multiply-accumulate (MAC) unit serially computes N_OUT neurons over N_IN inputs.
- Weights live in an on-chip, loadable register file.
- Selectable ReLU or linear activation with saturation. Activations cross in and out of the block with a valid/ready handshake.
- Sits between the state machine's forward-pass phases; one instance per layer.

---
 rtl/dense_pkg.sv | 43 ++++
 rtl/mac_unit.sv | 35 +++
 rtl/dense_layer_seq.sv | 172 +++++++++++++++++
 tb/tb_dense_layer_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared types and helpers for the time-multiplexed dense layer.
package dense_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StOut
    } state_e;

    // Counter/address width that never collapses to zero bits.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Accumulator width: full product plus headroom for N_IN terms.
    function automatic int unsigned acc_w(input int unsigned x_w, input int unsigned w_w,
                                          input int unsigned n_in);
        return x_w + w_w + 1 + $clog2(n_in);
    endfunction

    // ReLU with clamp to the unsigned range of an out_w-bit lane.
    function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                    input int unsigned out_w);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< out_w) - 64'sd1;
        if (v < 0) return '0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Clamp to the two's complement range of an out_w-bit lane.
    function automatic logic signed [63:0] sat_lin(input logic signed [63:0] v,
                                                   input int unsigned out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate: unsigned activation times signed weight.
// sum_o is the running total including the current product, so the caller
// can capture a finished dot product on the same cycle it clears.
module mac_unit #(
    parameter int unsigned X_W   = 4,
    parameter int unsigned W_W   = 4,
    parameter int unsigned ACC_W = 11
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic                    clr_i,
    input  logic [X_W-1:0]          x_i,
    input  logic signed [W_W-1:0]   w_i,
    output logic signed [ACC_W-1:0] sum_o
);

    logic signed [X_W+W_W:0]   prod;
    logic signed [ACC_W-1:0]   acc_q;

    assign prod  = $signed({1'b0, x_i}) * w_i;
    assign sum_o = acc_q + ACC_W'(prod);

    // Accumulator register; clear has priority over accumulate.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= sum_o;
        end
    end

endmodule

// File: rtl/dense_layer_seq.sv
// Time-multiplexed fully-connected layer: one MAC walks N_OUT neurons over
// N_IN inputs, with a loadable weight file and saturating activation.
module dense_layer_seq
    import dense_pkg::*;
#(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned N_OUT  = 8,
    parameter int unsigned X_W    = 4,
    parameter int unsigned W_W    = 4,
    parameter int unsigned OUT_W  = 10,
    parameter int          W_INIT = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         w_load_i,
    input  logic [cnt_w(N_IN*N_OUT)-1:0] w_addr_i,
    input  logic [W_W-1:0]               w_data_i,
    output logic                         w_err_o,
    input  logic                         mode_i,
    input  logic                         x_valid_i,
    output logic                         x_ready_o,
    input  logic [N_IN*X_W-1:0]          x_i,
    output logic                         y_valid_o,
    input  logic                         y_ready_i,
    output logic [N_OUT*OUT_W-1:0]       y_o,
    output logic                         busy_o
);

    localparam int unsigned NW    = N_IN * N_OUT;
    localparam int unsigned AW    = cnt_w(NW);
    localparam int unsigned IW    = cnt_w(N_IN);
    localparam int unsigned NNW   = cnt_w(N_OUT);
    localparam int unsigned ACC_W = acc_w(X_W, W_W, N_IN);

    state_e                  state_q, state_d;
    logic [IW-1:0]           i_q, i_d;
    logic [NNW-1:0]          n_q, n_d;
    logic [N_IN*X_W-1:0]     x_q, x_d;
    logic                    mode_q, mode_d;
    logic [N_OUT*OUT_W-1:0]  y_q, y_d;
    logic                    w_err_q;

    logic signed [W_W-1:0]   w_q [NW];
    logic                    w_in_range, w_we, w_reject;

    logic [AW-1:0]           w_idx;
    logic [X_W-1:0]          x_cur;
    logic signed [W_W-1:0]   w_cur;
    logic                    mac_en, mac_clr;
    logic signed [ACC_W-1:0] mac_sum;
    logic signed [63:0]      sum_ext, act;

    assign w_in_range = 32'(w_addr_i) < NW;
    assign w_we       = en_i && w_load_i && (state_q == StIdle) && w_in_range;
    assign w_reject   = en_i && w_load_i && ((state_q != StIdle) || !w_in_range);

    // Weight file: writes only land while idle, so the MAC never sees a torn update.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < int'(NW); k++) begin
                w_q[k] <= W_W'(W_INIT);
            end
        end else if (w_we) begin
            w_q[w_addr_i] <= w_data_i;
        end
    end

    // Sticky rejected-write flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            w_err_q <= 1'b0;
        end else if (w_reject) begin
            w_err_q <= 1'b1;
        end
    end

    assign w_idx = AW'(32'(n_q) * N_IN + 32'(i_q));
    assign x_cur = x_q[i_q*X_W +: X_W];
    assign w_cur = w_q[w_idx];

    mac_unit #(
        .X_W   (X_W),
        .W_W   (W_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk_i  (clk_i),
        .rst_ni (rst_i),
        .en_i   (mac_en),
        .clr_i  (mac_clr),
        .x_i    (x_cur),
        .w_i    (w_cur),
        .sum_o  (mac_sum)
    );

    assign sum_ext = 64'(mac_sum);
    assign act     = mode_q ? sat_relu(sum_ext, OUT_W) : sat_lin(sum_ext, OUT_W);

    // Next-state: sequence neurons/inputs and write each finished lane.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        n_d     = n_q;
        x_d     = x_q;
        mode_d  = mode_q;
        y_d     = y_q;
        mac_en  = 1'b0;
        mac_clr = 1'b0;
        if (en_i) begin
            unique case (state_q)
                StIdle: begin
                    if (x_valid_i) begin
                        x_d     = x_i;
                        mode_d  = mode_i;
                        mac_clr = 1'b1;
                        i_d     = '0;
                        n_d     = '0;
                        state_d = StMac;
                    end
                end
                StMac: begin
                    mac_en = 1'b1;
                    if (i_q == IW'(N_IN - 1)) begin
                        mac_clr                  = 1'b1;
                        i_d                      = '0;
                        y_d[n_q*OUT_W +: OUT_W]  = act[OUT_W-1:0];
                        if (n_q == NNW'(N_OUT - 1)) begin
                            state_d = StOut;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
                StOut: begin
                    if (y_ready_i) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            i_q     <= '0;
            n_q     <= '0;
            x_q     <= '0;
            mode_q  <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            n_q     <= n_d;
            x_q     <= x_d;
            mode_q  <= mode_d;
            y_q     <= y_d;
        end
    end

    // Ready is gated by reset so nothing looks acceptable while held in reset.
    assign x_ready_o = rst_i && en_i && (state_q == StIdle);
    assign y_valid_o = (state_q == StOut);
    assign busy_o    = (state_q != StIdle);
    assign y_o       = y_q;
    assign w_err_o   = w_err_q;

endmodule

// File: tb/tb_dense_layer_seq.sv
// Scoreboarded bench for dense_layer_seq with a plain-arithmetic reference model.
module tb_dense_layer_seq;

    localparam int NI = 4;
    localparam int NO = 6;
    localparam int XW = 4;
    localparam int WW = 4;
    localparam int OW = 8;
    localparam int NW = NI * NO;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              rst_n, en, w_load, w_err, mode, x_valid, x_ready;
    logic              y_valid, y_ready, busy;
    logic [AW-1:0]     w_addr;
    logic [WW-1:0]     w_data;
    logic [NI*XW-1:0]  x;
    logic [NO*OW-1:0]  y;

    int                total = 0;
    int                bad = 0;
    int                wm [NW];
    logic              exp_err;
    logic [NO*OW-1:0]  sb [$];
    logic [NI*XW-1:0]  x15;

    always #5 clk = ~clk;

    dense_layer_seq #(
        .N_IN   (NI),
        .N_OUT  (NO),
        .X_W    (XW),
        .W_W    (WW),
        .OUT_W  (OW),
        .W_INIT (1)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .en_i      (en),
        .w_load_i  (w_load),
        .w_addr_i  (w_addr),
        .w_data_i  (w_data),
        .w_err_o   (w_err),
        .mode_i    (mode),
        .x_valid_i (x_valid),
        .x_ready_o (x_ready),
        .x_i       (x),
        .y_valid_o (y_valid),
        .y_ready_i (y_ready),
        .y_o       (y),
        .busy_o    (busy)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Reference: dot products with plain integers, then clamp per activation rule.
    function automatic logic [NO*OW-1:0] model_y(input logic [NI*XW-1:0] xv, input logic md);
        logic [NO*OW-1:0] r;
        int s, hi, lo;
        r = '0;
        for (int n = 0; n < NO; n++) begin
            s = 0;
            for (int i = 0; i < NI; i++) s += int'(xv[i*XW +: XW]) * wm[n*NI+i];
            if (md) begin
                hi = (1 << OW) - 1;
                if (s < 0) s = 0;
                else if (s > hi) s = hi;
            end else begin
                hi = (1 << (OW - 1)) - 1;
                lo = -(1 << (OW - 1));
                if (s > hi) s = hi;
                else if (s < lo) s = lo;
            end
            r[n*OW +: OW] = s[OW-1:0];
        end
        return r;
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [WW-1:0] d);
        if (int'(a) < NW) wm[a] = int'($signed(d));
        else exp_err = 1'b1;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NW; k++) wm[k] = 1;
        exp_err = 1'b0;
    endfunction

    // Monitor: every completed output handshake pops one expected vector.
    always @(negedge clk) begin
        if (rst_n && en && y_valid && y_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got output %0h want none", y);
            end else begin
                chk("y_data", 64'(y), 64'(sb.pop_front()));
            end
        end
    end

    task automatic wr(input logic [AW-1:0] a, input logic [WW-1:0] d);
        en = 1'b1;
        w_load = 1'b1;
        w_addr = a;
        w_data = d;
        model_write(a, d);
        @(posedge clk); #2;
        w_load = 1'b0;
    endtask

    task automatic load_all(input logic [WW-1:0] d);
        for (int a = 0; a < NW; a++) wr(AW'(a), d);
    endtask

    task automatic run_vec(input logic [NI*XW-1:0] xv, input logic md, input int stall_pct,
                           input int hold, input bit mac_wr, input bit acc_wr);
        int   guard, lat;
        logic rdy, en_now;
        x = xv;
        mode = md;
        x_valid = 1'b1;
        en = 1'b1;
        if (acc_wr) begin
            w_load = 1'b1;
            w_addr = AW'($urandom_range(0, NW - 1));
            w_data = WW'($urandom_range(0, 15));
            model_write(w_addr, w_data);
        end
        guard = 0;
        rdy = 1'b0;
        while (!rdy && guard < 50) begin
            @(negedge clk);
            rdy = x_ready;
            @(posedge clk); #2;
            w_load = 1'b0;
            guard++;
        end
        x_valid = 1'b0;
        chk("accept_first_cycle", 64'(guard), 64'(1));
        sb.push_back(model_y(xv, md));
        lat = 0;
        guard = 0;
        while (!y_valid && guard < 2000) begin
            en_now = (guard == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
            en = en_now;
            if (mac_wr && guard == 0) begin
                w_load = 1'b1;
                w_addr = '0;
                w_data = WW'(5);
                exp_err = 1'b1;
            end
            @(posedge clk); #2;
            w_load = 1'b0;
            if (en_now) lat++;
            guard++;
        end
        en = 1'b1;
        chk("latency", 64'(lat), 64'(NW));
        chk("out_valid", 64'(y_valid), 64'(1));
        y_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_x_ready", 64'(x_ready), 64'(0));
            chk("hold_valid", 64'(y_valid), 64'(1));
            if (sb.size() > 0) chk("hold_y", 64'(y), 64'(sb[0]));
            @(posedge clk); #2;
        end
        y_ready = 1'b1;
        @(negedge clk);
        chk("release_x_ready", 64'(x_ready), 64'(0));
        @(posedge clk); #2;
        y_ready = 1'b0;
        chk("idle_valid", 64'(y_valid), 64'(0));
        chk("idle_x_ready", 64'(x_ready), 64'(1));
        chk("w_err", 64'(w_err), 64'(exp_err));
    endtask

    initial begin
        int cnt;
        logic [NI*XW-1:0] xr;
        x15 = '1;
        rst_n = 1'b0;
        en = 1'b1;
        w_load = 1'b0;
        w_addr = '0;
        w_data = '0;
        mode = 1'b0;
        x_valid = 1'b0;
        x = '0;
        y_ready = 1'b0;
        model_reset();

        // Reset state.
        @(negedge clk);
        chk("rst_x_ready", 64'(x_ready), 64'(0));
        chk("rst_y_valid", 64'(y_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_y", 64'(y), 64'(0));
        chk("rst_w_err", 64'(w_err), 64'(0));
        @(posedge clk); #2;
        rst_n = 1'b1;
        en = 1'b0;
        @(negedge clk);
        chk("en_low_x_ready", 64'(x_ready), 64'(0));
        en = 1'b1;
        @(negedge clk);
        chk("en_high_x_ready", 64'(x_ready), 64'(1));
        @(posedge clk); #2;

        // Default weights, all-15 inputs.
        run_vec(x15, 1'b1, 0, 2, 1'b0, 1'b0);

        // All weights -1: ReLU floors, linear goes negative.
        load_all(WW'(-1));
        run_vec(x15, 1'b1, 0, 1, 1'b0, 1'b0);
        run_vec(x15, 1'b0, 0, 1, 1'b0, 1'b0);

        // Saturation: +420 and -480 against 8-bit lanes.
        load_all(WW'(7));
        run_vec(x15, 1'b1, 0, 1, 1'b0, 1'b0);
        run_vec(x15, 1'b0, 0, 20, 1'b0, 1'b0);
        load_all(WW'(-8));
        run_vec(x15, 1'b0, 0, 1, 1'b0, 1'b0);

        // Rejected writes: during MAC and out of range; weights must not move.
        load_all(WW'(3));
        run_vec(x15, 1'b1, 0, 1, 1'b1, 1'b0);
        wr(AW'(NW), WW'(-8));
        wr(AW'(31), WW'(-8));
        chk("w_err_sticky", 64'(w_err), 64'(1));
        run_vec(x15, 1'b0, 0, 1, 1'b0, 1'b0);

        // Randomised weights, inputs, modes, stalls, writes alongside accepts.
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < NW; a++) wr(AW'(a), WW'($urandom_range(0, 15)));
            for (int v = 0; v < 6; v++) begin
                xr = NI*XW'($urandom());
                run_vec(xr, 1'($urandom_range(0, 1)), 30, $urandom_range(0, 4), 1'b0,
                        ($urandom_range(0, 2) == 0));
            end
        end

        // Reset in the middle of a pass with enable toggling.
        x = x15;
        mode = 1'b1;
        x_valid = 1'b1;
        en = 1'b1;
        @(posedge clk); #2;
        x_valid = 1'b0;
        cnt = 0;
        while (cnt < 10) begin
            en = 1'($urandom_range(0, 1));
            @(posedge clk); #2;
            if (en) cnt++;
        end
        en = 1'b1;
        chk("pre_rst_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_y_valid", 64'(y_valid), 64'(0));
        chk("abort_y", 64'(y), 64'(0));
        chk("abort_x_ready", 64'(x_ready), 64'(0));
        chk("abort_w_err", 64'(w_err), 64'(0));
        sb.delete();
        model_reset();
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_vec(x15, 1'b1, 40, 1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
